// File: rtl/multdiv_seq_if.sv
// Operand/control/result bundle between the execute stage and the sequential mul/div unit.
interface multdiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA,
    output data_operandB,
    output ctrl_MULT,
    output ctrl_DIV,
    input  data_result,
    input  data_exception,
    input  data_resultRDY
  );

  modport slave (
    input  data_operandA,
    input  data_operandB,
    input  ctrl_MULT,
    input  ctrl_DIV,
    output data_result,
    output data_exception,
    output data_resultRDY
  );
endinterface

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit,
// one iteration per clock, fixed 33-cycle start-to-ready latency.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         clr,
  multdiv_seq_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StRunMult, StRunDiv, StDone} state_e;

  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  // acc_q: Booth accumulator or partial remainder; lo_q: multiplier or dividend/quotient.
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   opb_q;
  logic [WIDTH-1:0] lo_q;
  logic             qm1_q;
  logic             is_div_q;
  logic             neg_q;
  logic             dz_q;
  logic             ovf_q;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;

  logic             start;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_rem;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;
  logic             prod_ovf;
  logic [WIDTH-1:0] fin_result;
  logic             fin_exc;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    start   = bus_io.ctrl_MULT | bus_io.ctrl_DIV;
    // Negating MinVal yields MinVal, which read as unsigned is the correct magnitude.
    mag_a   = bus_io.data_operandA[WIDTH-1] ? -bus_io.data_operandA : bus_io.data_operandA;
    mag_b   = bus_io.data_operandB[WIDTH-1] ? -bus_io.data_operandB : bus_io.data_operandB;
    cnt_inc = cnt_q + 1'b1;

    booth_sum = acc_q;
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + opb_q;
      2'b10:   booth_sum = acc_q - opb_q;
      default: booth_sum = acc_q;
    endcase

    div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ge    = (div_shift >= opb_q);
    div_rem   = div_ge ? (div_shift - opb_q) : div_shift;

    prod     = {acc_q[WIDTH-1:0], lo_q};
    prod_ovf = ~(&prod[2*WIDTH-1:WIDTH-1]) & (|prod[2*WIDTH-1:WIDTH-1]);

    if (!is_div_q) begin
      fin_result = prod[WIDTH-1:0];
      fin_exc    = prod_ovf;
    end else if (dz_q) begin
      fin_result = '0;
      fin_exc    = 1'b1;
    end else if (ovf_q) begin
      fin_result = MinVal;
      fin_exc    = 1'b1;
    end else begin
      fin_result = neg_q ? -lo_q : lo_q;
      fin_exc    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        // A start in any state aborts whatever is in flight.
        cnt_q    <= '0;
        acc_q    <= '0;
        qm1_q    <= 1'b0;
        is_div_q <= ~bus_io.ctrl_MULT;
        if (bus_io.ctrl_MULT) begin
          state_q <= StRunMult;
          lo_q    <= bus_io.data_operandB;
          opb_q   <= {bus_io.data_operandA[WIDTH-1], bus_io.data_operandA};
          neg_q   <= 1'b0;
          dz_q    <= 1'b0;
          ovf_q   <= 1'b0;
        end else begin
          state_q <= StRunDiv;
          lo_q    <= mag_a;
          opb_q   <= {1'b0, mag_b};
          neg_q   <= bus_io.data_operandA[WIDTH-1] ^ bus_io.data_operandB[WIDTH-1];
          dz_q    <= (bus_io.data_operandB == '0);
          ovf_q   <= (bus_io.data_operandA == MinVal) && (bus_io.data_operandB == '1);
        end
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StRunMult: begin
            acc_q <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lo_q  <= {booth_sum[0], lo_q[WIDTH-1:1]};
            qm1_q <= lo_q[0];
            cnt_q <= cnt_inc;
            if (cnt_inc == LastCnt) state_q <= StDone;
          end
          StRunDiv: begin
            acc_q <= div_rem;
            lo_q  <= {lo_q[WIDTH-2:0], div_ge};
            cnt_q <= cnt_inc;
            if (cnt_inc == LastCnt) state_q <= StDone;
          end
          StDone: begin
            result_q <= fin_result;
            exc_q    <= fin_exc;
            rdy_q    <= 1'b1;
            state_q  <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus_io.data_result    = result_q;
  assign bus_io.data_exception = exc_q;
  assign bus_io.data_resultRDY = rdy_q;

endmodule
